// File: rtl/cell_button_conditioner.sv
// Nine-button front end for the tic_tac_toe core: synchronise, debounce, reject chords, one press pulse.
// Optional stuck-button detection is compiled in with CELL_BTN_STUCK_DETECT_EN.
module cell_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
`ifdef CELL_BTN_STUCK_DETECT_EN
  ,
  parameter int STUCK_CYCLES    = 50000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btn_raw,
  output logic [8:0] cell_press,
  output logic       press_valid,
  output logic       busy,
  output logic       chord_err
`ifdef CELL_BTN_STUCK_DETECT_EN
  ,
  output logic       stuck_flag
`endif
);

  // state | meaning
  // IDLE  | waiting for a debounced press
  // PRESS | single press accepted, pulse cell_press for one cycle
  // HOLD  | press forwarded, waiting for debounced all-release
  // CHORD | several buttons debounced together, nothing forwarded
  typedef enum logic [1:0] {IDLE, PRESS, HOLD, CHORD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             rst_meta;
  logic             rst_b_sync;
  logic [8:0]       sync1;
  logic [8:0]       sync2;
  logic [8:0]       p_sync;
  logic [8:0]       p_prev;
  logic [8:0]       deb;
  logic [8:0]       deb_prev;
  logic [CNT_W-1:0] cnt;
  logic             deb_one;
  logic             deb_multi;
  logic             in_chord_q;
  state_t           state;
  state_t           state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta   <= 1'b0;
      rst_b_sync <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_b_sync <= rst_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_b_sync) begin
    if (!rst_b_sync) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign p_sync = ~sync2;

  // A cycle in which p_sync has just changed counts as the first stable cycle of the new value.
  always_ff @(posedge clk or negedge rst_b_sync) begin
    if (!rst_b_sync) begin
      p_prev   <= '0;
      deb      <= '0;
      deb_prev <= '0;
      cnt      <= '0;
    end else begin
      p_prev   <= p_sync;
      deb_prev <= deb;
      if (p_sync == deb) begin
        cnt <= '0;
      end else if (p_sync != p_prev) begin
        cnt <= CNT_W'(1);
      end else if (cnt >= CNT_LAST) begin
        deb <= p_sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign deb_one   = (deb != 9'd0) && ((deb & (deb - 9'd1)) == 9'd0);
  assign deb_multi = (deb != 9'd0) && !deb_one;

  always_ff @(posedge clk or negedge rst_b_sync) begin
    if (!rst_b_sync) begin
      state      <= IDLE;
      in_chord_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_chord_q <= (state == CHORD);
    end
  end

  always_comb begin
    state_nxt   = state;
    cell_press  = '0;
    press_valid = 1'b0;
    busy        = 1'b0;
    chord_err   = 1'b0;
    case (state)
      IDLE: begin
        if (deb_one) begin
          state_nxt = PRESS;
        end else if (deb_multi) begin
          state_nxt = CHORD;
        end
      end
      PRESS: begin
        cell_press  = deb;
        press_valid = 1'b1;
        busy        = 1'b1;
        state_nxt   = HOLD;
      end
      HOLD: begin
        busy      = 1'b1;
        chord_err = |(deb & ~deb_prev);
        if (deb == 9'd0) begin
          state_nxt = IDLE;
        end
      end
      CHORD: begin
        busy      = 1'b1;
        chord_err = !in_chord_q;
        if (deb == 9'd0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CELL_BTN_STUCK_DETECT_EN
  localparam int HC_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(STUCK_CYCLES);

  logic [HC_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_b_sync) begin
    if (!rst_b_sync) begin
      hold_cnt   <= '0;
      stuck_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        hold_cnt <= '0;
      end else if ((state == HOLD || state == CHORD) && hold_cnt != HC_MAX) begin
        hold_cnt <= hold_cnt + HC_W'(1);
      end
      if (hold_cnt == HC_MAX) begin
        stuck_flag <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cell_button_conditioner.sv
// Randomised and directed bench for cell_button_conditioner against a window-based reference model.
// Define CELL_BTN_STUCK_DETECT_EN to also exercise stuck_flag.
module tb_cell_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] btn_raw = 9'h1FF;
  logic [8:0] cell_press;
  logic       press_valid;
  logic       busy;
  logic       chord_err;
`ifdef CELL_BTN_STUCK_DETECT_EN
  logic       stuck_flag;
`endif

  always #5 clk = ~clk;

  cell_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8)
`ifdef CELL_BTN_STUCK_DETECT_EN
    ,
    .STUCK_CYCLES(100)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .cell_press(cell_press),
    .press_valid(press_valid),
    .busy(busy),
    .chord_err(chord_err)
`ifdef CELL_BTN_STUCK_DETECT_EN
    ,
    .stuck_flag(stuck_flag)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the debounced vector follows p_sync once the last D samples agree;
  // an engagement starts on a debounced press and ends on a debounced all-release.
  logic [8:0] raw_q[$];
  logic [8:0] win[$];
  logic [8:0] m_deb;
  bit         m_active = 1'b0;
  bit         engaged, pulse_now, chord_grp, chord_now;
  logic [8:0] exp_press;
  bit         exp_valid, exp_busy, exp_chord;

  int         cyc, pulse_cnt, chord_cnt, pulse_at;
  logic [8:0] last_cell;

  task automatic model_init();
    raw_q.delete();
    raw_q.push_back(9'h000);
    raw_q.push_back(9'h000);
    win.delete();
    m_deb     = 9'h000;
    engaged   = 0;
    pulse_now = 0;
    chord_grp = 0;
    chord_now = 0;
  endtask

  task automatic model_step();
    logic [8:0] ps;
    logic [8:0] dv_old;
    bit         all_eq;
    ps = raw_q.pop_front();
    raw_q.push_back(~btn_raw);
    dv_old = m_deb;
    win.push_back(ps);
    if (win.size() > D) void'(win.pop_front());
    if (win.size() == D) begin
      all_eq = 1;
      foreach (win[i]) if (win[i] != win[0]) all_eq = 0;
      if (all_eq && win[0] != m_deb) m_deb = win[0];
    end
    if (!engaged) begin
      if ($countones(dv_old) == 1) begin
        engaged   = 1;
        pulse_now = 1;
      end else if ($countones(dv_old) > 1) begin
        engaged   = 1;
        chord_grp = 1;
        chord_now = 1;
      end
    end else if (pulse_now) begin
      pulse_now = 0;
    end else begin
      chord_now = 0;
      if (dv_old == 9'h000) begin
        engaged   = 0;
        chord_grp = 0;
      end
    end
    exp_press = pulse_now ? m_deb : 9'h000;
    exp_valid = pulse_now;
    exp_busy  = engaged;
    exp_chord = chord_now || (engaged && !pulse_now && !chord_grp && ((m_deb & ~dv_old) != 9'h000));
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_active) model_step();
    @(negedge clk);
    if (m_active) begin
      check_eq("cell_press", 32'(cell_press), 32'(exp_press));
      check_eq("press_valid", 32'(press_valid), 32'(exp_valid));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("chord_err", 32'(chord_err), 32'(exp_chord));
    end else begin
      check_eq("rst_outputs", {20'd0, cell_press, press_valid, busy, chord_err}, 32'd0);
    end
    cyc++;
    if (press_valid) begin
      pulse_cnt++;
      last_cell = cell_press;
      pulse_at  = cyc;
    end
    if (chord_err) chord_cnt++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b0;
    m_active = 0;
    #1;
    check_eq("rst_async_clear", {20'd0, cell_press, press_valid, busy, chord_err}, 32'd0);
    repeat (n) tick();
    reset = 1'b1;
    repeat (2) tick();
    model_init();
    m_active = 1;
  endtask

  task automatic clear_counts();
    cyc       = 0;
    pulse_cnt = 0;
    chord_cnt = 0;
    pulse_at  = 0;
    last_cell = 9'h000;
  endtask

  task automatic hold(input logic [8:0] pressed, input int n);
    btn_raw = ~pressed;
    repeat (n) tick();
  endtask

  initial begin
    int rel_at;
    logic [8:0] one9;
    logic [8:0] mask;
    int r;
    one9 = 9'h001;
    model_init();

    // reset and quiet period
    do_reset(3);
    clear_counts();
    hold(9'h000, 20);
    check_eq("idle_no_pulse", 32'(pulse_cnt), 32'd0);
    check_eq("idle_no_chord", 32'(chord_cnt), 32'd0);

    // clean press on e
    clear_counts();
    hold(9'h010, 30);
    check_eq("e_pulse_count", 32'(pulse_cnt), 32'd1);
    check_eq("e_cell", 32'(last_cell), 32'h010);
    check_eq("e_latency", 32'(pulse_at), 32'(2 + D + 1));
    btn_raw = 9'h1FF;
    rel_at  = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (!busy && rel_at == 0) rel_at = i;
    end
    check_eq("e_release_lat", 32'(rel_at), 32'(2 + D + 1));

    // bounce on a, then stable
    clear_counts();
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 9'h001 : 9'h000, 2);
    check_eq("bounce_no_pulse", 32'(pulse_cnt), 32'd0);
    hold(9'h001, 20);
    check_eq("bounce_pulse_count", 32'(pulse_cnt), 32'd1);
    check_eq("bounce_cell", 32'(last_cell), 32'h001);
    hold(9'h000, 20);

    // chord c+g, then i alone
    clear_counts();
    hold(9'h044, 20);
    check_eq("chord_err_count", 32'(chord_cnt), 32'd1);
    check_eq("chord_no_pulse", 32'(pulse_cnt), 32'd0);
    hold(9'h000, 20);
    hold(9'h100, 20);
    check_eq("after_chord_pulse", 32'(pulse_cnt), 32'd1);
    check_eq("after_chord_cell", 32'(last_cell), 32'h100);
    hold(9'h000, 20);

    // late second button
    clear_counts();
    hold(9'h002, 15);
    hold(9'h00A, 15);
    check_eq("late_chord_count", 32'(chord_cnt), 32'd1);
    check_eq("late_pulse_count", 32'(pulse_cnt), 32'd1);
    hold(9'h008, 15);
    check_eq("late_still_busy", 32'(busy), 32'd1);
    hold(9'h000, 15);
    check_eq("late_idle", 32'(busy), 32'd0);

    // reset while holding h
    clear_counts();
    hold(9'h080, 15);
    check_eq("h_busy_hold", 32'(busy), 32'd1);
    do_reset(2);
    clear_counts();
    hold(9'h080, 20);
    check_eq("h_repress_count", 32'(pulse_cnt), 32'd1);
    check_eq("h_repress_cell", 32'(last_cell), 32'h080);
    hold(9'h000, 20);

    // randomised segments
    for (int s = 0; s < 80; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) mask = 9'h000;
      else if (r < 8) mask = one9 << $urandom_range(0, 8);
      else mask = (one9 << $urandom_range(0, 8)) | (one9 << $urandom_range(0, 8));
      hold(mask, int'($urandom_range(1, 12)));
    end
    hold(9'h000, 20);
    check_eq("random_end_idle", 32'(busy), 32'd0);

`ifdef CELL_BTN_STUCK_DETECT_EN
    hold(9'h020, 60);
    check_eq("stuck_early", 32'(stuck_flag), 32'd0);
    hold(9'h020, 90);
    check_eq("stuck_set", 32'(stuck_flag), 32'd1);
    hold(9'h000, 20);
    check_eq("stuck_sticky", 32'(stuck_flag), 32'd1);
    do_reset(2);
    check_eq("stuck_cleared", 32'(stuck_flag), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
